// File: rtl/dpram_pkg.sv
`default_nettype none
// ============================================================================
// Module : dpram_pkg
// Brief  : Shared definitions for the clearable dual-port RAM: clear-engine
//          state encodings, the default fill value, and a helper that picks
//          the state the clear engine wakes up in after reset.
// Rev    : 1.0  initial release
// ============================================================================
package dpram_pkg;

  // Clear-engine states; one bit is enough for the two-state engine.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_t;

  // Default fill value; sliced down to the data width at the top level.
  localparam logic [63:0] C_FILL_DEFAULT = 64'h0;

  // State the engine is forced into while rst_n is low.
  function automatic clr_state_t rst_state(input bit clr_on_rst);
    return clr_on_rst ? ST_CLEAR : ST_IDLE;
  endfunction

endpackage : dpram_pkg
`default_nettype wire

// File: rtl/ram_clr_seq.sv
`default_nettype none
// ============================================================================
// Module : ram_clr_seq
// Brief  : Clear sequencer. Walks an address counter across the whole RAM,
//          one word per cycle, and reports ownership of the write path.
// Ports  : clk      - clock, rising edge
//          rst_n    - asynchronous active-low reset
//          clr      - single-cycle clear request (ignored while clearing)
//          busy     - registered, high while clearing
//          clr_we   - clear write enable for the RAM
//          clr_addr - address being cleared this cycle
// Rev    : 1.0  initial release
// ============================================================================
module ram_clr_seq
  import dpram_pkg::*;
#(
  parameter int AW         = 13,
  parameter bit CLR_ON_RST = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  localparam logic [AW-1:0] C_LAST_ADDR = '1;

  clr_state_t    r_state;
  clr_state_t    w_state_nxt;
  logic [AW-1:0] r_ccnt;
  logic [AW-1:0] w_ccnt_nxt;
  logic          r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= rst_state(CLR_ON_RST);
      r_ccnt  <= '0;
      r_busy  <= CLR_ON_RST;
    end else begin
      r_state <= w_state_nxt;
      r_ccnt  <= w_ccnt_nxt;
      // busy is a dedicated flop tracking the next state so it never glitches.
      r_busy  <= (w_state_nxt == ST_CLEAR);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ccnt_nxt  = r_ccnt;
    if (r_state == ST_CLEAR) begin
      // The counter wraps to zero on the final word, so it is already
      // zero whenever CLEAR is entered again.
      w_ccnt_nxt = r_ccnt + 1'b1;
      if (r_ccnt == C_LAST_ADDR) begin
        w_state_nxt = ST_IDLE;
      end
    end else begin
      w_ccnt_nxt = '0;
      if (clr) begin
        w_state_nxt = ST_CLEAR;
      end
    end
  end

  assign busy     = r_busy;
  assign clr_we   = r_busy;
  assign clr_addr = r_ccnt;

endmodule : ram_clr_seq
`default_nettype wire

// File: rtl/dpram_clr.sv
`default_nettype none
// ============================================================================
// Module : dpram_clr
// Brief  : True dual-port RAM with a built-in clear engine that fills every
//          word with FILL. Both ports are read-first with registered outputs.
// Ports  : clk, rst_n                - clock / async active-low reset
//          addr, din, we, cs, dout   - port A (we, cs active-low)
//          addrb, dinb, web, csb,
//          doutb                     - port B (web, csb active-low)
//          clr                       - start a clear (active-high pulse)
//          busy                      - clear in progress, user writes dropped
// Rev    : 1.0  initial release
// ============================================================================
module dpram_clr
  import dpram_pkg::*;
#(
  parameter int            AW         = 13,
  parameter int            DW         = 8,
  parameter logic [DW-1:0] FILL       = C_FILL_DEFAULT[DW-1:0],
  parameter bit            CLR_ON_RST = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  input  logic          we,
  input  logic          cs,
  output logic [DW-1:0] dout,
  input  logic [AW-1:0] addrb,
  input  logic [DW-1:0] dinb,
  input  logic          web,
  input  logic          csb,
  output logic [DW-1:0] doutb,
  input  logic          clr,
  output logic          busy
);

  localparam int DEPTH = 1 << AW;

  logic          w_busy;
  logic          w_clr_we;
  logic [AW-1:0] w_clr_addr;

  logic          w_we_a;
  logic [AW-1:0] w_waddr_a;
  logic [DW-1:0] w_wdata_a;
  logic          w_we_b;

  logic [DW-1:0] r_mem [0:DEPTH-1];
  logic [DW-1:0] r_dout;
  logic [DW-1:0] r_doutb;

  ram_clr_seq #(
    .AW         (AW),
    .CLR_ON_RST (CLR_ON_RST)
  ) u_clr_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .busy     (w_busy),
    .clr_we   (w_clr_we),
    .clr_addr (w_clr_addr)
  );

  // The clear engine borrows port A's write side; user writes are dropped
  // while it runs. Port A reads keep using the user address.
  assign w_we_a    = w_busy ? w_clr_we   : (!cs && !we);
  assign w_waddr_a = w_busy ? w_clr_addr : addr;
  assign w_wdata_a = w_busy ? FILL       : din;

  // Port B yields to port A on an address collision so the RAM never sees
  // two writes to one word.
  assign w_we_b = !csb && !web && !w_busy && !(w_we_a && (w_waddr_a == addrb));

  // Storage: no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (w_we_b) begin
      r_mem[addrb] <= dinb;
    end
    if (w_we_a) begin
      r_mem[w_waddr_a] <= w_wdata_a;
    end
  end

  // Read-first: the non-blocking read sees the contents before this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout  <= '0;
      r_doutb <= '0;
    end else begin
      if (!cs) begin
        r_dout <= r_mem[addr];
      end
      if (!csb) begin
        r_doutb <= r_mem[addrb];
      end
    end
  end

  assign dout  = r_dout;
  assign doutb = r_doutb;
  assign busy  = w_busy;

endmodule : dpram_clr
`default_nettype wire

// File: doc/dpram_clr.md
DPRAM_CLR -- requirements
Module: dpram_clr

Interface
REQ-001 SHALL have parameter AW, default 13: address width; depth is 2^AW words.
REQ-002 SHALL have parameter DW, default 8: data width.
REQ-003 SHALL have parameter FILL, default 0 (DW bits): value written by the clear engine.
REQ-004 SHALL have parameter CLR_ON_RST, default 1: when 1, a clear starts automatically on reset release.
REQ-005 SHALL have these ports (name, direction, width, meaning):
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- addr  in  AW  port A address.
- din  in  DW  port A write data.
- we  in  1  port A write enable, active-low.
- cs  in  1  port A chip select, active-low.
- dout  out  DW  port A read data, registered.
- addrb  in  AW  port B address.
- dinb  in  DW  port B write data.
- web  in  1  port B write enable, active-low.
- csb  in  1  port B chip select, active-low.
- doutb  out  DW  port B read data, registered.
- clr  in  1  single-cycle clear request, active-high.
- busy  out  1  high while the clear engine owns the write path.

Function
REQ-006 Port A: when cs=0 and we=0, the RAM SHALL write din to addr at the clock edge.
REQ-007 Port A: when cs=0, dout SHALL load mem[addr] one cycle later; a same-cycle same-port write returns the old data (read-first). When cs=1, dout SHALL hold.
REQ-008 Port B SHALL behave identically to port A using addrb, dinb, web, csb and doutb.
REQ-009 When both ports write the same address in the same cycle, port A's data SHALL be stored.
REQ-010 When one port writes and the other port reads the same address in the same cycle, the reader SHALL get the old data.
REQ-011 The clear FSM SHALL have two states, IDLE and CLEAR, and a counter ccnt of AW bits.
REQ-012 On entering CLEAR, ccnt SHALL be 0; each CLEAR cycle SHALL write FILL to mem[ccnt] and then increment ccnt.
REQ-013 The cycle that writes address 2^AW-1 SHALL be the last CLEAR cycle; the FSM SHALL return to IDLE on the next edge, so a clear lasts exactly 2^AW cycles.
REQ-014 IDLE -> CLEAR SHALL occur on clr=1 in IDLE.
REQ-015 clr asserted while in CLEAR SHALL be ignored, with no restart.
REQ-016 busy SHALL equal (state==CLEAR), driven from a register.
REQ-017 While busy=1, port A and port B writes SHALL be discarded.
REQ-018 While busy=1, reads SHALL still execute per REQ-007/008 and return current contents, which may be partly cleared.

Reset
REQ-019 rst_n=0 SHALL asynchronously set dout=0, doutb=0 and ccnt=0.
REQ-020 rst_n=0 SHALL asynchronously set the FSM to CLEAR if CLR_ON_RST=1, else to IDLE.
REQ-021 Memory contents SHALL NOT be reset by rst_n.
REQ-022 If reset is asserted mid-clear, the clear SHALL restart from address 0 (CLR_ON_RST=1) or abandon (CLR_ON_RST=0).
REQ-023 With CLR_ON_RST=1, busy SHALL be 1 from reset assertion until the clear completes.

Structure
REQ-024 Reset-state encodings for IDLE/CLEAR and the default FILL constant SHALL live in the shared package dpram_pkg.
REQ-025 The FSM and counter SHALL be the sub-module ram_clr_seq, with outputs busy, clear-write-enable and clear-address.
REQ-026 The storage array SHALL be inferable as vendor true-dual-port block RAM; the clear write SHALL be muxed onto port A.
REQ-027 Port-B writes SHALL be suppressed in hardware whenever port A writes the same address (implements REQ-009).

Verification (AW=4, DW=8)
REQ-028 CLR_ON_RST=1, FILL=8'h5A, release rst_n -> busy=1 for exactly 16 cycles; afterwards, a read of every address on both ports returns 8'h5A.
REQ-029 IDLE; A writes 8'h11 to addr 3 while B reads addr 3 in the same cycle -> doutb=old value; next cycle B read of addr 3 -> 8'h11.
REQ-030 Both ports write addr 7 in the same cycle (A=8'hAA, B=8'h55) -> subsequent read of addr 7 returns 8'hAA.
REQ-031 clr pulse, then a port A write of 8'hFF to addr 15 on cycle 2 of CLEAR -> write discarded; addr 15 reads FILL afterwards; a second clr pulse during CLEAR does not extend busy past 16 cycles.
REQ-032 rst_n asserted at ccnt=9 -> dout, doutb and busy update immediately; after release, the clear restarts at address 0 and busy lasts 16 cycles.
REQ-033 cs=1 with addr changing -> dout holds its last value.
